// File: rtl/pkg_mem.sv
// Shared types and widths for the CRAM load back-end arbiter.
package pkg_mem;

    localparam int unsigned LD_ARB_CNT_W = 16;
    localparam int unsigned LD_LEN_W     = 8;

    typedef enum logic [1:0] {
        LD_ARB_IDLE,
        LD_ARB_ISSUE,
        LD_ARB_BUSY,
        LD_ARB_DONE
    } fsm_ld_arb;

    // Load attributes captured from the winning requester
    typedef struct packed {
        logic [LD_LEN_W-1:0] length;
        logic                indirect;
        logic                bypass;
    } ld_attr_t;

endpackage

// File: rtl/rr_select.sv
// Circular priority encoder: first set request at or after ptr, wrapping around.
module rr_select #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot_c,
    output logic [IDX_W-1:0]   idx_c,
    output logic               valid_c
);

    int unsigned pos;

    always_comb begin
        onehot_c = '0;
        idx_c    = '0;
        valid_c  = 1'b0;
        pos      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!valid_c && req[IDX_W'(pos)]) begin
                valid_c                = 1'b1;
                onehot_c[IDX_W'(pos)]  = 1'b1;
                idx_c                  = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ld_backend_arbiter.sv
// Round-robin arbiter/sequencer sharing one CRAM load back-end among NUM_REQ requesters.
module ld_backend_arbiter
    import pkg_mem::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          I_Req,
    input  logic [NUM_REQ*LD_LEN_W-1:0] I_Length,
    input  logic [NUM_REQ-1:0]          I_Indirect,
    input  logic [NUM_REQ-1:0]          I_Bypass,
    input  logic                        I_End_Block,
    input  logic                        I_End_Term_Block,
    input  logic                        I_Term_AddrGen,
    output logic                        O_Event_Load,
    output logic [LD_LEN_W-1:0]         O_Length,
    output logic                        O_Indirect,
    output logic                        O_Bypass,
    output logic [NUM_REQ-1:0]          O_Grant,
    output logic [NUM_REQ-1:0]          O_Ack,
    output logic                        O_Abort,
    output logic                        O_Busy
);

    localparam int unsigned                 IDX_W   = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]            IDX_MAX = IDX_W'(NUM_REQ - 1);
    localparam logic [LD_ARB_CNT_W-1:0]     WD_LAST = LD_ARB_CNT_W'(TIMEOUT - 1);
    localparam bit                          WD_EN   = (TIMEOUT != 0);

    fsm_ld_arb                 r_state;
    logic [IDX_W-1:0]          r_ptr;
    logic [IDX_W-1:0]          r_idx;
    logic [LD_ARB_CNT_W-1:0]   r_cnt;
    logic                      r_end_prev;
    ld_attr_t                  r_attr;

    logic [NUM_REQ-1:0]        sel_onehot_c;
    logic [IDX_W-1:0]          sel_idx_c;
    logic                      sel_valid_c;
    ld_attr_t                  sel_attr_c;
    logic [LD_LEN_W-1:0]       len_arr_c [NUM_REQ];

    logic                      end_rise_c;
    logic                      complete_c;
    logic                      wd_expire_c;
    logic [IDX_W-1:0]          ptr_next_c;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req      (I_Req),
        .ptr      (r_ptr),
        .onehot_c (sel_onehot_c),
        .idx_c    (sel_idx_c),
        .valid_c  (sel_valid_c)
    );

    // Unpack the flat per-requester length bus
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign len_arr_c[g] = I_Length[g*LD_LEN_W +: LD_LEN_W];
    end

    always_comb begin
        sel_attr_c          = '0;
        sel_attr_c.length   = len_arr_c[sel_idx_c];
        sel_attr_c.indirect = I_Indirect[sel_idx_c];
        sel_attr_c.bypass   = I_Bypass[sel_idx_c];
    end

    // End of block is level; only a fresh rising edge counts as completion
    assign end_rise_c  = I_End_Block & ~r_end_prev;
    assign complete_c  = end_rise_c | I_End_Term_Block | I_Term_AddrGen;
    assign wd_expire_c = WD_EN && (r_cnt == WD_LAST);
    assign ptr_next_c  = (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);

    assign O_Length   = r_attr.length;
    assign O_Indirect = r_attr.indirect;
    assign O_Bypass   = r_attr.bypass;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= LD_ARB_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_end_prev   <= 1'b0;
            r_attr       <= '0;
            O_Event_Load <= 1'b0;
            O_Grant      <= '0;
            O_Ack        <= '0;
            O_Abort      <= 1'b0;
            O_Busy       <= 1'b0;
        end else begin
            r_end_prev   <= I_End_Block;
            O_Event_Load <= 1'b0;
            O_Ack        <= '0;
            O_Abort      <= 1'b0;
            case (r_state)
                LD_ARB_IDLE: begin
                    if (sel_valid_c) begin
                        r_idx        <= sel_idx_c;
                        r_attr       <= sel_attr_c;
                        O_Grant      <= sel_onehot_c;
                        O_Event_Load <= 1'b1;
                        O_Busy       <= 1'b1;
                        r_state      <= LD_ARB_ISSUE;
                    end
                end
                LD_ARB_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= LD_ARB_BUSY;
                end
                LD_ARB_BUSY: begin
                    // Completion takes priority over a coincident watchdog expiry
                    if (complete_c) begin
                        O_Ack   <= O_Grant;
                        r_state <= LD_ARB_DONE;
                    end else if (wd_expire_c) begin
                        O_Ack   <= O_Grant;
                        O_Abort <= 1'b1;
                        r_state <= LD_ARB_DONE;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + LD_ARB_CNT_W'(1);
                    end
                end
                LD_ARB_DONE: begin
                    r_ptr   <= ptr_next_c;
                    O_Grant <= '0;
                    O_Busy  <= 1'b0;
                    r_state <= LD_ARB_IDLE;
                end
                default: begin
                    r_state <= LD_ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ld_backend_arbiter.sv
// Scoreboard bench for ld_backend_arbiter: directed services, monitor checks grants, acks and latencies.
module tb_ld_backend_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  I_Req = '0;
    logic [31:0] I_Length;
    logic [3:0]  I_Indirect;
    logic [3:0]  I_Bypass;
    logic        I_End_Block = 1'b0;
    logic        I_End_Term_Block = 1'b0;
    logic        I_Term_AddrGen = 1'b0;
    logic        O_Event_Load;
    logic [7:0]  O_Length;
    logic        O_Indirect;
    logic        O_Bypass;
    logic [3:0]  O_Grant;
    logic [3:0]  O_Ack;
    logic        O_Abort;
    logic        O_Busy;

    // Second instance with the watchdog disabled
    logic [3:0]  u0_req = '0;
    logic        zero1 = 1'b0;
    logic        u0_event;
    logic [7:0]  u0_len;
    logic        u0_ind;
    logic        u0_byp;
    logic [3:0]  u0_grant;
    logic [3:0]  u0_ack;
    logic        u0_abort;
    logic        u0_busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;
    bit          rst_q    = 1'b0;

    typedef struct {
        logic [3:0]  grant;
        logic [7:0]  len;
        logic        ind;
        logic        byp;
        logic        abort;
        int unsigned dly;
        bit          b2b;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  len_tab [4] = '{8'h11, 8'h05, 8'hA3, 8'hFE};
    logic [3:0]  ind_tab = 4'b0110;
    logic [3:0]  byp_tab = 4'b1100;

    ld_backend_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) u_dut (
        .clock            (clock),
        .reset            (reset),
        .I_Req            (I_Req),
        .I_Length         (I_Length),
        .I_Indirect       (I_Indirect),
        .I_Bypass         (I_Bypass),
        .I_End_Block      (I_End_Block),
        .I_End_Term_Block (I_End_Term_Block),
        .I_Term_AddrGen   (I_Term_AddrGen),
        .O_Event_Load     (O_Event_Load),
        .O_Length         (O_Length),
        .O_Indirect       (O_Indirect),
        .O_Bypass         (O_Bypass),
        .O_Grant          (O_Grant),
        .O_Ack            (O_Ack),
        .O_Abort          (O_Abort),
        .O_Busy           (O_Busy)
    );

    ld_backend_arbiter #(.NUM_REQ(4), .TIMEOUT(0)) u_dut0 (
        .clock            (clock),
        .reset            (reset),
        .I_Req            (u0_req),
        .I_Length         (I_Length),
        .I_Indirect       (I_Indirect),
        .I_Bypass         (I_Bypass),
        .I_End_Block      (zero1),
        .I_End_Term_Block (zero1),
        .I_Term_AddrGen   (zero1),
        .O_Event_Load     (u0_event),
        .O_Length         (u0_len),
        .O_Indirect       (u0_ind),
        .O_Bypass         (u0_byp),
        .O_Grant          (u0_grant),
        .O_Ack            (u0_ack),
        .O_Abort          (u0_abort),
        .O_Busy           (u0_busy)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int idx, input logic abort, input int unsigned dly, input bit b2b);
        exp_t e;
        logic [3:0] one;
        one     = 4'b0001;
        e.grant = one << idx;
        e.len   = len_tab[2'(idx)];
        e.ind   = ind_tab[2'(idx)];
        e.byp   = byp_tab[2'(idx)];
        e.abort = abort;
        e.dly   = dly;
        e.b2b   = b2b;
        return e;
    endfunction

    // Monitor: compares every load event and every acknowledge against the scoreboard
    int unsigned ev_cyc = 0;
    int unsigned last_ack_cyc = 0;
    always @(negedge clock) begin
        exp_t e;
        if (rst_q) begin
            check("reset_outputs",
                  32'({O_Event_Load, O_Length, O_Indirect, O_Bypass, O_Grant, O_Ack, O_Abort, O_Busy}), 32'd0);
            sb.delete();
        end else begin
            if (O_Event_Load === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 32'(O_Grant), 32'd0);
                end else begin
                    e = sb[0];
                    check("event_grant", 32'(O_Grant), 32'(e.grant));
                    check("event_length", 32'(O_Length), 32'(e.len));
                    check("event_flags", 32'({O_Indirect, O_Bypass}), 32'({e.ind, e.byp}));
                    if (e.b2b) check("b2b_gap", cyc - last_ack_cyc, 32'd2);
                    ev_cyc = cyc;
                end
            end
            if (O_Ack !== 4'b0000 && O_Ack !== 4'bxxxx) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(O_Ack), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_vector", 32'(O_Ack), 32'(e.grant));
                    check("ack_grant_held", 32'(O_Grant), 32'(e.grant));
                    check("ack_abort", 32'(O_Abort), 32'(e.abort));
                    check("ack_attr_stable", 32'({O_Length, O_Indirect, O_Bypass}), 32'({e.len, e.ind, e.byp}));
                    check("ack_latency", cyc - ev_cyc, e.dly);
                end
                last_ack_cyc = cyc;
            end else if (O_Abort === 1'b1) begin
                check("abort_without_ack", 32'(O_Abort), 32'd0);
            end
        end
    end

    task automatic wait_ev();
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (O_Event_Load === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("event_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (O_Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int unsigned acks;
        int unsigned aborts;
        bit ok;
        I_Length   = {len_tab[3], len_tab[2], len_tab[1], len_tab[0]};
        I_Indirect = ind_tab;
        I_Bypass   = byp_tab;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Single requester 1, end of block rises 6 cycles after the event
        sb.push_back(mk(1, 1'b0, 7, 1'b0));
        I_Req = 4'b0010;
        wait_ev();
        I_Req = 4'b0000;
        repeat (6) @(negedge clock);
        I_End_Block = 1'b1;
        wait_idle();

        // End of block still high: needs a fall and a new rise; length changes mid-service
        sb.push_back(mk(2, 1'b0, 6, 1'b0));
        I_Req = 4'b0100;
        wait_ev();
        I_Req = 4'b0000;
        @(negedge clock);
        I_Length[23:16] = 8'h00;
        repeat (2) @(negedge clock);
        I_End_Block = 1'b0;
        repeat (2) @(negedge clock);
        I_End_Block = 1'b1;
        wait_idle();
        I_Length    = {len_tab[3], len_tab[2], len_tab[1], len_tab[0]};
        I_End_Block = 1'b0;

        // Pointer at 3, only requester 0: wrap-around; terminal block during ISSUE is ignored
        sb.push_back(mk(0, 1'b0, 3, 1'b0));
        I_Req = 4'b0001;
        wait_ev();
        I_Req = 4'b0000;
        I_End_Term_Block = 1'b1;
        @(negedge clock);
        I_End_Term_Block = 1'b0;
        @(negedge clock);
        I_End_Term_Block = 1'b1;
        @(negedge clock);
        I_End_Term_Block = 1'b0;
        wait_idle();

        // Pointer at 1: requester 3 wins, drops its request, AGU ends it; requester 0 follows back-to-back
        sb.push_back(mk(3, 1'b0, 2, 1'b0));
        sb.push_back(mk(0, 1'b0, 2, 1'b1));
        I_Req = 4'b1001;
        wait_ev();
        I_Req = 4'b0001;
        @(negedge clock);
        I_Term_AddrGen = 1'b1;
        @(negedge clock);
        I_Term_AddrGen = 1'b0;
        wait_ev();
        I_Req = 4'b0000;
        @(negedge clock);
        I_End_Block      = 1'b1;
        I_End_Term_Block = 1'b1;
        @(negedge clock);
        I_End_Term_Block = 1'b0;
        wait_idle();
        I_End_Block = 1'b0;

        // Completion in the same cycle the watchdog would expire: completion wins
        sb.push_back(mk(1, 1'b0, 17, 1'b0));
        I_Req = 4'b0010;
        wait_ev();
        I_Req = 4'b0000;
        repeat (16) @(negedge clock);
        I_Term_AddrGen = 1'b1;
        @(negedge clock);
        I_Term_AddrGen = 1'b0;
        wait_idle();

        // Watchdog expiry with no completion
        sb.push_back(mk(2, 1'b1, 17, 1'b0));
        I_Req = 4'b0100;
        wait_ev();
        I_Req = 4'b0000;
        repeat (20) @(negedge clock);
        wait_idle();

        // Reset in the middle of BUSY: outstanding service is discarded with no ack
        sb.push_back(mk(3, 1'b0, 0, 1'b0));
        I_Req = 4'b1000;
        wait_ev();
        I_Req = 4'b0000;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Fairness from pointer 0 with all requests held
        sb.push_back(mk(0, 1'b0, 2, 1'b0));
        sb.push_back(mk(1, 1'b0, 2, 1'b1));
        sb.push_back(mk(2, 1'b0, 2, 1'b1));
        sb.push_back(mk(3, 1'b0, 2, 1'b1));
        sb.push_back(mk(0, 1'b0, 2, 1'b1));
        I_Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ev();
            if (k == 4) I_Req = 4'b0000;
            @(negedge clock);
            I_Term_AddrGen = 1'b1;
            @(negedge clock);
            I_Term_AddrGen = 1'b0;
        end
        wait_idle();

        // Watchdog disabled: service never ends on its own
        u0_req = 4'b0001;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (u0_event === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("wd_off_event", 32'(ok), 32'd1);
        check("wd_off_grant", 32'(u0_grant), 32'd1);
        u0_req = 4'b0000;
        acks   = 0;
        aborts = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (u0_ack !== 4'b0000) acks++;
            if (u0_abort !== 1'b0) aborts++;
        end
        check("wd_off_busy", 32'(u0_busy), 32'd1);
        check("wd_off_acks", acks, 32'd0);
        check("wd_off_aborts", aborts, 32'd0);

        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
